// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus: per-stage stall requests and MEM-stage events in,
// stall vector, flush/redirect and stall status out.
interface pipe_ctrl_if;
  logic        i_stallreq_if;
  logic        i_stallreq_id;
  logic        i_stallreq_ex;
  logic        i_stallreq_mem;
  logic [6:0]  i_except;
  logic        i_eret;
  logic [31:0] i_epc;
  logic [5:0]  o_stall;
  logic        o_flush;
  logic [31:0] o_new_pc;
  logic [31:0] o_stall_cnt;
  logic        o_timeout;

  modport master (
    output i_stallreq_if, i_stallreq_id, i_stallreq_ex, i_stallreq_mem,
    output i_except, i_eret, i_epc,
    input  o_stall, o_flush, o_new_pc, o_stall_cnt, o_timeout
  );

  modport slave (
    input  i_stallreq_if, i_stallreq_id, i_stallreq_ex, i_stallreq_mem,
    input  i_except, i_eret, i_epc,
    output o_stall, o_flush, o_new_pc, o_stall_cnt, o_timeout
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 6-stage pipeline: merges stall requests,
// turns MEM-stage exceptions/ERET into a held flush with redirect PC.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'hBFC0_0380,
  parameter int unsigned FLUSH_HOLD    = 1,
  parameter int unsigned STALL_TIMEOUT = 1023
) (
  input logic       clk,
  input logic       reset,
  pipe_ctrl_if.slave bus
);

  localparam int unsigned HoldW = (FLUSH_HOLD > 2) ? $clog2(FLUSH_HOLD) : 1;
  localparam int unsigned RunW  = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT + 1) : 1;
  localparam logic [RunW-1:0] RunMax = RunW'(STALL_TIMEOUT);

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  state_e            state_q, state_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [31:0]       new_pc_q, new_pc_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [RunW-1:0]   run_q, run_d;
  logic              timeout_q, timeout_d;

  logic        ev;
  logic [31:0] target;
  logic        flush;
  logic [31:0] new_pc;
  logic [5:0]  stall_raw;
  logic [5:0]  stall;
  logic        stalled;

  always_comb begin
    ev     = (bus.i_except != 7'd0) | bus.i_eret;
    target = (bus.i_except != 7'd0) ? EXC_VECTOR : bus.i_epc;
  end

  // Each requester freezes its own stage and everything upstream of it.
  always_comb begin
    if (bus.i_stallreq_mem)     stall_raw = 6'b011111;
    else if (bus.i_stallreq_ex) stall_raw = 6'b001111;
    else if (bus.i_stallreq_id) stall_raw = 6'b000111;
    else if (bus.i_stallreq_if) stall_raw = 6'b000011;
    else                        stall_raw = 6'b000000;
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    new_pc_d = new_pc_q;
    flush    = 1'b0;
    new_pc   = new_pc_q;
    unique case (state_q)
      StIdle: begin
        if (ev) begin
          flush    = 1'b1;
          new_pc   = target;
          new_pc_d = target;
          if (FLUSH_HOLD > 1) begin
            state_d = StFlush;
            hold_d  = HoldW'(FLUSH_HOLD - 2);
          end
        end
      end
      StFlush: begin
        flush = 1'b1;
        if (hold_q == '0) state_d = StIdle;
        else              hold_d  = hold_q - HoldW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    stall     = flush ? 6'b000000 : stall_raw;
    stalled   = (stall != 6'b000000);
    cnt_d     = cnt_q + 32'(stalled);
    if (!stalled)             run_d = '0;
    else if (run_q != RunMax) run_d = run_q + RunW'(1);
    else                      run_d = run_q;
    timeout_d = timeout_q | (stalled && (run_d == RunMax));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      hold_q    <= '0;
      new_pc_q  <= '0;
      cnt_q     <= '0;
      run_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      new_pc_q  <= new_pc_d;
      cnt_q     <= cnt_d;
      run_q     <= run_d;
      timeout_q <= timeout_d;
    end
  end

  // Combinational outputs are masked so nothing leaks out while reset is held.
  always_comb begin
    bus.o_stall     = reset ? stall : 6'b000000;
    bus.o_flush     = reset & flush;
    bus.o_new_pc    = reset ? new_pc : 32'd0;
    bus.o_stall_cnt = cnt_q;
    bus.o_timeout   = timeout_q;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table, hand-written
// reset/timeout sequences and randomized traffic against a reference model.
module tb_pipe_ctrl;
  localparam logic [31:0] Exc  = 32'hBFC0_0380;
  localparam int          Hold = 3;
  localparam int          To   = 4;

  logic clk;
  logic reset;
  pipe_ctrl_if bus ();

  pipe_ctrl #(
    .EXC_VECTOR   (Exc),
    .FLUSH_HOLD   (Hold),
    .STALL_TIMEOUT(To)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state: flush cycles still owed, latched PC, counters.
  int          m_left;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  int          m_run;
  bit          m_to;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_comb(input logic [3:0] req, input logic [6:0] exc,
                                     input logic eret, input logic [31:0] epc,
                                     output logic [5:0] st, output logic fl,
                                     output logic [31:0] pc);
    if (m_left > 0) begin
      fl = 1'b1; pc = m_pc; st = 6'd0;
    end else if (exc != 0 || eret) begin
      fl = 1'b1; pc = (exc != 0) ? Exc : epc; st = 6'd0;
    end else begin
      fl = 1'b0; pc = m_pc;
      // Stage k requester freezes stages 0..k+1 -> (2^(k+2))-1
      if (req[3])      st = 6'((1 << 5) - 1);
      else if (req[2]) st = 6'((1 << 4) - 1);
      else if (req[1]) st = 6'((1 << 3) - 1);
      else if (req[0]) st = 6'((1 << 2) - 1);
      else             st = 6'd0;
    end
  endfunction

  function automatic void model_step(input logic [3:0] req, input logic [6:0] exc,
                                     input logic eret, input logic [31:0] epc);
    logic [5:0]  st;
    logic        fl;
    logic [31:0] pc;
    model_comb(req, exc, eret, epc, st, fl, pc);
    if (m_left > 0) m_left--;
    else if (exc != 0 || eret) begin
      m_pc   = pc;
      m_left = Hold - 1;
    end
    if (st != 0) begin
      m_cnt++;
      if (m_run < To) m_run++;
      if (m_run == To) m_to = 1'b1;
    end else begin
      m_run = 0;
    end
  endfunction

  function automatic void model_reset();
    m_left = 0; m_pc = 0; m_cnt = 0; m_run = 0; m_to = 1'b0;
  endfunction

  task automatic drive(input logic [3:0] req, input logic [6:0] exc, input logic eret,
                       input logic [31:0] epc);
    bus.i_stallreq_if  = req[0];
    bus.i_stallreq_id  = req[1];
    bus.i_stallreq_ex  = req[2];
    bus.i_stallreq_mem = req[3];
    bus.i_except       = exc;
    bus.i_eret         = eret;
    bus.i_epc          = epc;
  endtask

  // Called 1 time unit after a rising edge; returns 1 after the next one.
  task automatic apply(input string tag, input logic [3:0] req, input logic [6:0] exc,
                       input logic eret, input logic [31:0] epc, input logic [5:0] exp_st,
                       input logic exp_fl, input logic [31:0] exp_pc);
    drive(req, exc, eret, epc);
    #2;
    chk({tag, ".stall"}, 32'(bus.o_stall), 32'(exp_st));
    chk({tag, ".flush"}, 32'(bus.o_flush), 32'(exp_fl));
    chk({tag, ".new_pc"}, bus.o_new_pc, exp_pc);
    chk({tag, ".stall_cnt"}, bus.o_stall_cnt, m_cnt);
    chk({tag, ".timeout"}, 32'(bus.o_timeout), 32'(m_to));
    @(posedge clk);
    model_step(req, exc, eret, epc);
    #1;
  endtask

  task automatic apply_model(input string tag, input logic [3:0] req, input logic [6:0] exc,
                             input logic eret, input logic [31:0] epc);
    logic [5:0]  st;
    logic        fl;
    logic [31:0] pc;
    model_comb(req, exc, eret, epc, st, fl, pc);
    apply(tag, req, exc, eret, epc, st, fl, pc);
  endtask

  // Holds reset for 3 edges with an event and stall pending; outputs must stay 0.
  task automatic do_reset(input string tag);
    drive(4'b1000, 7'h11, 1'b1, 32'hDEAD_BEEF);
    reset = 1'b0;
    #1;
    chk({tag, ".rst_flush"}, 32'(bus.o_flush), 32'd0);
    chk({tag, ".rst_stall"}, 32'(bus.o_stall), 32'd0);
    chk({tag, ".rst_new_pc"}, bus.o_new_pc, 32'd0);
    chk({tag, ".rst_cnt"}, bus.o_stall_cnt, 32'd0);
    chk({tag, ".rst_timeout"}, 32'(bus.o_timeout), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    drive(4'b0000, 7'd0, 1'b0, 32'd0);
    reset = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [3:0]  req;   // {mem, ex, id, if}
    logic [6:0]  exc;
    logic        eret;
    logic [31:0] epc;
    logic [5:0]  st;
    logic        fl;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[15];

  initial begin
    reset = 1'b0;
    drive(4'b0000, 7'd0, 1'b0, 32'd0);
    model_reset();

    vecs[0]  = '{4'b0100, 7'h00, 1'b0, 32'h0,         6'b001111, 1'b0, 32'h0};
    vecs[1]  = '{4'b0100, 7'h00, 1'b0, 32'h0,         6'b001111, 1'b0, 32'h0};
    vecs[2]  = '{4'b1000, 7'h00, 1'b0, 32'h0,         6'b011111, 1'b0, 32'h0};
    vecs[3]  = '{4'b0000, 7'h00, 1'b0, 32'h0,         6'b000000, 1'b0, 32'h0};
    vecs[4]  = '{4'b1000, 7'h04, 1'b0, 32'h0,         6'b000000, 1'b1, 32'hBFC0_0380};
    vecs[5]  = '{4'b0000, 7'h00, 1'b1, 32'h1234_5678, 6'b000000, 1'b1, 32'hBFC0_0380};
    vecs[6]  = '{4'b1000, 7'h00, 1'b0, 32'h0,         6'b000000, 1'b1, 32'hBFC0_0380};
    vecs[7]  = '{4'b0001, 7'h00, 1'b0, 32'h0,         6'b000011, 1'b0, 32'hBFC0_0380};
    vecs[8]  = '{4'b0000, 7'h00, 1'b1, 32'h8000_1234, 6'b000000, 1'b1, 32'h8000_1234};
    vecs[9]  = '{4'b0000, 7'h00, 1'b0, 32'h0,         6'b000000, 1'b1, 32'h8000_1234};
    vecs[10] = '{4'b0010, 7'h00, 1'b0, 32'h0,         6'b000000, 1'b1, 32'h8000_1234};
    vecs[11] = '{4'b0000, 7'h01, 1'b1, 32'h8000_1234, 6'b000000, 1'b1, 32'hBFC0_0380};
    vecs[12] = '{4'b0000, 7'h00, 1'b0, 32'h0,         6'b000000, 1'b1, 32'hBFC0_0380};
    vecs[13] = '{4'b0000, 7'h00, 1'b0, 32'h0,         6'b000000, 1'b1, 32'hBFC0_0380};
    vecs[14] = '{4'b0110, 7'h00, 1'b0, 32'h0,         6'b001111, 1'b0, 32'hBFC0_0380};

    @(posedge clk);
    #1;
    do_reset("t1");
    #1;
    chk("t1.flush", 32'(bus.o_flush), 32'd0);
    chk("t1.stall", 32'(bus.o_stall), 32'd0);
    chk("t1.new_pc", bus.o_new_pc, 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) begin
      apply($sformatf("vec%0d", i), vecs[i].req, vecs[i].exc, vecs[i].eret, vecs[i].epc,
            vecs[i].st, vecs[i].fl, vecs[i].pc);
      if (i == 2) chk("t2.stall_cnt", bus.o_stall_cnt, 32'd3);
    end

    // Stall timeout: rises after the 4th stalled cycle and is sticky.
    do_reset("t5");
    for (int i = 0; i < 6; i++) begin
      apply($sformatf("t5.id%0d", i), 4'b0010, 7'd0, 1'b0, 32'd0, 6'b000111, 1'b0, 32'd0);
      if (i == 2) chk("t5.timeout_before", 32'(bus.o_timeout), 32'd0);
      if (i == 3) chk("t5.timeout_rise", 32'(bus.o_timeout), 32'd1);
    end
    chk("t5.stall_cnt", bus.o_stall_cnt, 32'd6);
    apply_model("t5.drop0", 4'b0000, 7'd0, 1'b0, 32'd0);
    apply_model("t5.drop1", 4'b0000, 7'd0, 1'b0, 32'd0);
    chk("t5.timeout_sticky", 32'(bus.o_timeout), 32'd1);
    do_reset("t5b");

    // Reset asserted in the middle of a flush hold.
    apply("t6.ev", 4'b0000, 7'h02, 1'b0, 32'd0, 6'd0, 1'b1, Exc);
    drive(4'b0000, 7'd0, 1'b0, 32'd0);
    #2;
    chk("t6.hold_flush", 32'(bus.o_flush), 32'd1);
    reset = 1'b0;
    #1;
    chk("t6.rst_flush", 32'(bus.o_flush), 32'd0);
    chk("t6.rst_new_pc", bus.o_new_pc, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    apply("t6.eret", 4'b0000, 7'd0, 1'b1, 32'hA000_0040, 6'd0, 1'b1, 32'hA000_0040);
    apply("t6.hold1", 4'b1000, 7'd0, 1'b0, 32'd0, 6'd0, 1'b1, 32'hA000_0040);
    apply("t6.hold2", 4'b1000, 7'd0, 1'b0, 32'd0, 6'd0, 1'b1, 32'hA000_0040);
    apply("t6.after", 4'b1000, 7'd0, 1'b0, 32'd0, 6'b011111, 1'b0, 32'hA000_0040);

    // Randomized traffic against the model, with periodic resets.
    for (int i = 0; i < 400; i++) begin
      logic [3:0]  req;
      logic [6:0]  exc;
      logic        eret;
      logic [31:0] epc;
      if (i % 100 == 99) do_reset("rnd");
      req  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      exc  = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(1, 127)) : 7'd0;
      eret = ($urandom_range(0, 9) == 0);
      epc  = $urandom;
      apply_model($sformatf("rnd%0d", i), req, exc, eret, epc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
